word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial transmitter: accepts an 8-bit word over a valid/ready load handshake and shifts it out one bit per enabled cycle.
- Bit order is selectable per word: MSB-first, or LSB-first (the bit-reversed word).
- Serial output carries frame-start and last-bit markers, plus a wrapping sent-frame counter with wrap flag.
- It is the transmit end that feeds the counter/reverse-bits datapath with serial words.

## Interface
Parameters:
- WIDTH, 8, word width in bits; must be ≥ 2.
- CNT_W, 8, width of the sent-frame counter.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- din  input  WIDTH  parallel word to send.
- load_valid  input  1  din is valid.
- load_ready  output  1  block can accept a word; high exactly in IDLE.
- lsb_first  input  1  bit order for this word: 1 = LSB-first, 0 = MSB-first. Sampled only at load.
- en  input  1  bit-rate enable; one bit is emitted per cycle with en=1 in SHIFT.
- sout  output  1  serial data bit, registered.
- sout_valid  output  1  sout carries a bit this cycle, registered.
- frame_start  output  1  high with the first bit of a word, registered.
- last  output  1  high with the final bit of a word, registered.
- frames_sent  output  CNT_W  count of completed words; wraps to 0.
- OV  output  1  one-cycle pulse when frames_sent wraps from all-ones to 0.

## Operation
- States: IDLE and SHIFT.
- **IDLE**
  - load_ready=1.
  - On load_valid=1: capture din into shreg. If lsb_first=1, capture reverse(din) instead.
  - Clear bit_cnt and go to SHIFT.
  - din with load_valid=0 is ignored.
- **SHIFT**
  - load_ready=0; load_valid is ignored.
  - On a cycle with en=1:
    - register sout=shreg[WIDTH-1] and sout_valid=1;
    - register frame_start=(bit_cnt==0) and last=(bit_cnt==WIDTH-1);
    - shift shreg left by one with 0 fill;
    - increment bit_cnt.
  - On the en cycle where bit_cnt==WIDTH-1:
    - return to IDLE;
    - increment frames_sent modulo 2^CNT_W;
    - if frames_sent was all-ones, register OV=1.
  - On a cycle with en=0: shreg and bit_cnt hold; sout_valid, frame_start, last and OV register 0; sout holds its last value.
- In IDLE, sout_valid, frame_start, last and OV register 0.
- bit_cnt is ceil(log2(WIDTH)) bits wide and never exceeds WIDTH-1.
- A load and an en in the same IDLE cycle: only the load takes effect. The first bit is emitted on the next en cycle.
- lsb_first changing during SHIFT has no effect on the word in flight.

## Timing
- Reset values:
  - state=IDLE, load_ready=1, shreg=0, bit_cnt=0.
  - sout=0, sout_valid=0, frame_start=0, last=0, frames_sent=0, OV=0.
- Reset asserted mid-frame aborts the word: no further bits, frames_sent not incremented. After release the block is in IDLE.
- Latency: load cycle N, en held high → first bit visible (sout_valid=1) in cycle N+2. The last bit is visible in cycle N+WIDTH+1.
- load_ready returns to 1 in cycle N+WIDTH+1, concurrent with last=1.
- Peak throughput: one word per WIDTH+1 cycles with back-to-back loads.
- frames_sent and OV update in the same cycle last=1 is visible.
- OV is high for exactly one cycle per wrap.

## Structure
- Shared package holds:
  - WIDTH and CNT_W defaults;
  - state encoding constants ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - bit-count width derivation.
- One sub-module, `word_reverse`: purely combinational, forward[WIDTH-1:0] → reversed[WIDTH-1:0], reversed[i]=forward[WIDTH-1-i]. The same function is reused by the receive path.
- Top holds the FSM, shift register, bit counter, frame counter and output registers.

## Test plan
- Reset: assert Reset for 3 cycles mid-simulation → all outputs at reset values, load_ready=1.
- MSB-first: din=8'h1E, lsb_first=0, en=1 → sout sequence 0,0,0,1,1,1,1,0.
  - frame_start with the first bit, last with the eighth.
  - frames_sent 0→1.
- LSB-first: din=8'h1E, lsb_first=1, en=1 → sout sequence 0,1,1,1,1,0,0,0.
  - Toggling lsb_first mid-frame leaves the sequence unchanged.
- Gapped enable: din=8'hA5, en toggling 1,0,1,0… → eight sout_valid pulses spaced 2 cycles apart, bits 1,0,1,0,0,1,0,1.
  - load_valid asserted during SHIFT is ignored (load_ready=0).
- Abort: load 8'hFF, assert Reset after 3 bits → no further sout_valid, frames_sent=0.
  - A subsequent load of 8'h80 sends 1,0,0,0,0,0,0,0.
- Wrap: 256 back-to-back words with en=1 → frames_sent goes 8'hFF→8'h00 with a single-cycle OV=1 coincident with last=1. Each word completes in 9 cycles.

Source files
------------

// File: rtl/word_serializer_pkg.sv
// Shared types and constants for the word serializer.
// Also used by the receive-side datapath.
package word_serializer_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Bit counter width: enough to index WIDTH bits.
  function automatic int bcnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/word_reverse.sv
// Combinational bit reversal of a WIDTH-bit word.
// Shared between the transmit and receive paths.
module word_reverse #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] forward,
  output logic [WIDTH-1:0] reversed
);

  // Mirror bit i onto bit WIDTH-1-i.
  always_comb begin
    reversed = '0;
    for (int i = 0; i < WIDTH; i++) begin
      reversed[i] = forward[WIDTH-1-i];
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial transmitter with frame markers
// and a wrapping sent-frame counter.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             lsb_first,
  input  logic             en,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             last,
  output logic [CNT_W-1:0] frames_sent,
  output logic             OV
);

  localparam int BCW = bcnt_w(WIDTH);
  localparam logic [BCW-1:0] LAST_IDX = BCW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [BCW-1:0]   bit_cnt;
  logic [WIDTH-1:0] din_rev;

  word_reverse #(
    .WIDTH(WIDTH)
  ) u_rev (
    .forward (din),
    .reversed(din_rev)
  );

  // Load/shift FSM with all outputs registered.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state       <= ST_IDLE;
      load_ready  <= 1'b1;
      shreg       <= '0;
      bit_cnt     <= '0;
      sout        <= 1'b0;
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      last        <= 1'b0;
      frames_sent <= '0;
      OV          <= 1'b0;
    end else begin
      sout_valid  <= 1'b0;
      frame_start <= 1'b0;
      last        <= 1'b0;
      OV          <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (load_valid) begin
            shreg      <= lsb_first ? din_rev : din;
            bit_cnt    <= '0;
            state      <= ST_SHIFT;
            load_ready <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (en) begin
            sout        <= shreg[WIDTH-1];
            sout_valid  <= 1'b1;
            frame_start <= (bit_cnt == '0);
            last        <= (bit_cnt == LAST_IDX);
            shreg       <= {shreg[WIDTH-2:0], 1'b0};
            if (bit_cnt == LAST_IDX) begin
              bit_cnt     <= '0;
              state       <= ST_IDLE;
              load_ready  <= 1'b1;
              frames_sent <= frames_sent + CNT_W'(1);
              OV          <= &frames_sent;
            end else begin
              bit_cnt <= bit_cnt + BCW'(1);
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Self-checking bench for word_serializer.
// Table vectors, corner sequences and a random model.
module tb_word_serializer;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] din;
  logic       load_valid;
  logic       load_ready;
  logic       lsb_first;
  logic       en;
  logic       sout;
  logic       sout_valid;
  logic       frame_start;
  logic       last;
  logic [7:0] frames_sent;
  logic       OV;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_frames = 0;
  int ov_seen = 0;

  word_serializer #(
    .WIDTH(8),
    .CNT_W(8)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .din        (din),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .lsb_first  (lsb_first),
    .en         (en),
    .sout       (sout),
    .sout_valid (sout_valid),
    .frame_start(frame_start),
    .last       (last),
    .frames_sent(frames_sent),
    .OV         (OV)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       lsb;
    int         mode;
    bit         junk;
    bit         tog;
    logic [7:0] exp_seq;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (OV === 1'b1) ov_seen++;
  endtask

  // Bit i of a frame, from the bit-order rule.
  function automatic logic mbit(input logic [7:0] d, input logic lsb,
                                input int i);
    return lsb ? d[i] : d[7-i];
  endfunction

  task automatic chk_reset_vals();
    chk("rst_load_ready", load_ready, 1);
    chk("rst_sout", sout, 0);
    chk("rst_sout_valid", sout_valid, 0);
    chk("rst_frame_start", frame_start, 0);
    chk("rst_last", last, 0);
    chk("rst_frames_sent", frames_sent, 0);
    chk("rst_ov", OV, 0);
  endtask

  // mode: 0 = en held, 1 = en 1,0,1,0..., 2 = random en
  task automatic send(input logic [7:0] d, input logic lsb,
                      input int mode, input bit junk, input bit tog,
                      input logic [7:0] exp_seq, input bit use_exp);
    logic [7:0] got;
    logic       en_prev;
    logic       exp_ov;
    int         k;
    int         t;
    bit         done;
    got  = '0;
    k    = 0;
    done = 0;
    chk("ready_idle", load_ready, 1);
    din        = d;
    lsb_first  = lsb;
    load_valid = 1'b1;
    en         = 1'b1;
    tick();
    t = 1;
    chk("no_bit_on_load", sout_valid, 0);
    chk("ready_drop", load_ready, 0);
    chk("ov_after_load", OV, 0);
    load_valid = 1'b0;
    for (int j = 0; j < 64 && !done; j++) begin
      case (mode)
        0:       en = 1'b1;
        1:       en = (j % 2 == 0);
        default: en = ($urandom_range(3) != 0);
      endcase
      en_prev = en;
      if (junk) begin
        load_valid = 1'b1;
        din        = ~d;
      end
      if (tog) lsb_first = 1'($urandom_range(1));
      tick();
      t++;
      chk("valid_follows_en", sout_valid, en_prev);
      if (sout_valid) begin
        chk("bit", sout, mbit(d, lsb, k));
        chk("frame_start", frame_start, k == 0);
        chk("last", last, k == 7);
        got = {got[6:0], sout};
        if (k == 7) begin
          exp_ov     = (exp_frames == 255);
          exp_frames = (exp_frames + 1) % 256;
          chk("frames_sent", frames_sent, exp_frames);
          chk("ov", OV, exp_ov);
          chk("ready_back", load_ready, 1);
          if (mode == 0) chk("word_cycles", t, 9);
          done = 1;
        end else begin
          chk("busy", load_ready, 0);
          chk("ov_mid", OV, 0);
        end
        k++;
      end
    end
    load_valid = 1'b0;
    chk("word_done", done, 1);
    if (use_exp) chk("word", got, exp_seq);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    int nb;
    Reset      = 1'b1;
    din        = '0;
    load_valid = 1'b0;
    lsb_first  = 1'b0;
    en         = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
    tick();
    chk_reset_vals();

    tbl[0] = '{8'h1E, 1'b0, 0, 1'b0, 1'b0, 8'b0001_1110};
    tbl[1] = '{8'h1E, 1'b1, 0, 1'b0, 1'b1, 8'b0111_1000};
    tbl[2] = '{8'hA5, 1'b0, 1, 1'b1, 1'b0, 8'b1010_0101};
    tbl[3] = '{8'h01, 1'b1, 0, 1'b0, 1'b0, 8'b1000_0000};
    tbl[4] = '{8'h0F, 1'b1, 1, 1'b1, 1'b1, 8'b1111_0000};
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].d, tbl[i].lsb, tbl[i].mode, tbl[i].junk,
           tbl[i].tog, tbl[i].exp_seq, 1'b1);
    end

    en    = 1'b1;
    Reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals();
    Reset = 1'b0;
    exp_frames = 0;
    tick();
    chk_reset_vals();

    din        = 8'hFF;
    lsb_first  = 1'b0;
    load_valid = 1'b1;
    en         = 1'b1;
    tick();
    load_valid = 1'b0;
    nb = 0;
    for (int j = 0; j < 20 && nb < 3; j++) begin
      tick();
      if (sout_valid) nb++;
    end
    chk("abort_bits_seen", nb, 3);
    Reset = 1'b1;
    repeat (3) tick();
    Reset = 1'b0;
    stray = 0;
    for (int j = 0; j < 12; j++) begin
      tick();
      if (sout_valid !== 1'b0) stray++;
    end
    chk("abort_no_bits", stray, 0);
    chk("abort_frames", frames_sent, 0);
    chk("abort_ready", load_ready, 1);
    exp_frames = 0;

    send(8'h80, 1'b0, 0, 1'b0, 1'b0, 8'b1000_0000, 1'b1);

    ov_seen = 0;
    for (int i = 0; i < 256; i++) begin
      send(8'($urandom), 1'($urandom_range(1)), 0, 1'b0, 1'b0,
           8'h00, 1'b0);
    end
    chk("wrap_ov_count", ov_seen, 1);

    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 1'($urandom_range(1)), 2,
           1'($urandom_range(1)), 1'b1, 8'h00, 1'b0);
    end
    chk("final_ov_count", ov_seen, 1);
    chk("final_frames", frames_sent, exp_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
